// File: rtl/otg_hpi_sequencer.sv
// otg_hpi_sequencer: Avalon-MM slave that runs one timed CY7C67200 HPI read or write cycle per CTRL write.
// Define OTG_HPI_IRQ_EN to add the irq output and the CTRL[3] irq_en bit.
module otg_hpi_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  otg_hpi_addr,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
`ifdef OTG_HPI_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LD    = CNT_W'(RECOVERY_CYC - 1);

  localparam logic [1:0] A_WDATA  = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RDATA  = 2'd3;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      wdata;
  logic [15:0]      rdata;
  logic [1:0]       port;
  logic             dir;
  logic             done;
  logic             err;
  logic             irq_en;

  logic reg_wr, wr_wdata, wr_ctrl, wr_status;
  logic busy, start, seg_end, to_post_hold, to_idle;
  logic unused_wdata_hi;

  assign reg_wr    = chipselect && !write_n;
  assign wr_wdata  = reg_wr && (address == A_WDATA);
  assign wr_ctrl   = reg_wr && (address == A_CTRL);
  assign wr_status = reg_wr && (address == A_STATUS);

  assign busy    = (state != IDLE);
  assign start   = wr_ctrl && !busy;
  assign seg_end = (cnt == '0);

  // Leaving the cs_n-low part of the cycle, and finishing the whole transaction.
  assign to_post_hold = seg_end && (((state == STROBE) && (HOLD_CYC == 0)) || (state == HOLD));
  assign to_idle      = seg_end && ((state == RECOVER) || (to_post_hold && (RECOVERY_CYC == 0)));

  assign unused_wdata_hi = ^writedata[31:16];

  // Sequencer, register file and pin drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wdata        <= '0;
      rdata        <= '0;
      port         <= '0;
      dir          <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      otg_hpi_addr <= '0;
      otg_hpi_cs_n <= 1'b1;
      otg_hpi_r_n  <= 1'b1;
      otg_hpi_w_n  <= 1'b1;
      otg_data_out <= '0;
      otg_data_oe  <= 1'b0;
    end else begin
      if (wr_wdata && !busy) wdata <= writedata[15:0];
      if (wr_status) begin
        if (writedata[1]) done <= 1'b0;
        if (writedata[2]) err  <= 1'b0;
      end
      if ((wr_wdata || wr_ctrl) && busy) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            port         <= writedata[1:0];
            dir          <= writedata[2];
            done         <= 1'b0;
            state        <= SETUP;
            cnt          <= SETUP_LD;
            otg_hpi_addr <= writedata[1:0];
            otg_hpi_cs_n <= 1'b0;
            if (!writedata[2]) begin
              otg_data_out <= wdata;
              otg_data_oe  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (seg_end) begin
            state       <= STROBE;
            cnt         <= STROBE_LD;
            otg_hpi_r_n <= ~dir;
            otg_hpi_w_n <= dir;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (seg_end) begin
            otg_hpi_r_n <= 1'b1;
            otg_hpi_w_n <= 1'b1;
            if (dir) rdata <= otg_data_in;
            if (HOLD_CYC != 0) begin
              state <= HOLD;
              cnt   <= HOLD_LD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD, RECOVER: begin
          if (!seg_end) cnt <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase

      if (to_post_hold) begin
        otg_hpi_cs_n <= 1'b1;
        otg_data_oe  <= 1'b0;
        otg_data_out <= '0;
        if (RECOVERY_CYC != 0) begin
          state <= RECOVER;
          cnt   <= REC_LD;
        end
      end

      // Completion beats a same-clock STATUS clear of done.
      if (to_idle) begin
        state        <= IDLE;
        otg_hpi_addr <= '0;
        done         <= 1'b1;
      end
    end
  end

`ifdef OTG_HPI_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_en <= 1'b0;
    else if (start) irq_en <= writedata[3];
  end

  assign irq = done & irq_en;
`else
  assign irq_en = 1'b0;
`endif

  // Avalon read mux.
  always_comb begin
    readdata = '0;
    case (address)
      A_WDATA:  readdata = {16'h0, wdata};
      A_CTRL:   readdata = {28'h0, irq_en, dir, port};
      A_STATUS: readdata = {29'h0, err, done, busy};
      A_RDATA:  readdata = {16'h0, rdata};
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Randomised, self-checking bench for otg_hpi_sequencer against a timeline model of one HPI transaction.
// Build with OTG_HPI_IRQ_EN defined to also cover the irq output.
module tb_otg_hpi_sequencer;

  localparam int S = 1, T = 4, H = 1, R = 2;
  localparam int TOTAL = S + T + H + R;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  otg_hpi_addr;
  logic        otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;
`ifdef OTG_HPI_IRQ_EN
  logic        irq;
`endif

  otg_hpi_sequencer #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVERY_CYC(R)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .otg_hpi_addr(otg_hpi_addr), .otg_hpi_cs_n(otg_hpi_cs_n), .otg_hpi_r_n(otg_hpi_r_n),
    .otg_hpi_w_n(otg_hpi_w_n), .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
    .otg_data_in(otg_data_in)
`ifdef OTG_HPI_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline, m_t = clocks since the edge that accepted CTRL.
  bit          m_active;
  int          m_t;
  logic [1:0]  m_port;
  logic        m_dir;
  logic [15:0] m_wdata, m_rdata;
  logic        m_done, m_err;
  logic [3:0]  m_ctrl;
  bit          m_wr, m_busy, m_fin;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_t = 0; m_port = 0; m_dir = 0; m_wdata = 0; m_rdata = 0;
      m_done = 0; m_err = 0; m_ctrl = 0;
    end else begin
      m_wr   = chipselect && !write_n;
      m_busy = m_active;
      m_fin  = 0;
      if (m_active) begin
        if (m_dir && m_t == S + T - 1) m_rdata = otg_data_in;
        m_t++;
        if (m_t == TOTAL) begin m_active = 0; m_fin = 1; end
      end
      if (m_wr && address == 2'd2) begin
        if (writedata[1]) m_done = 0;
        if (writedata[2]) m_err = 0;
      end
      if (m_wr && address <= 2'd1 && m_busy) m_err = 1;
      if (m_wr && address == 2'd0 && !m_busy) m_wdata = writedata[15:0];
      if (m_wr && address == 2'd1 && !m_busy) begin
        m_active = 1; m_t = 0; m_port = writedata[1:0]; m_dir = writedata[2]; m_done = 0;
`ifdef OTG_HPI_IRQ_EN
        m_ctrl = writedata[3:0];
`else
        m_ctrl = {1'b0, writedata[2:0]};
`endif
      end
      if (m_fin) m_done = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        cs_low, str_low, oe;
      logic [31:0] exp_rd;
      cs_low  = m_active && m_t < S + T + H;
      str_low = m_active && m_t >= S && m_t < S + T;
      oe      = cs_low && !m_dir;
      case (address)
        2'd0:    exp_rd = {16'h0, m_wdata};
        2'd1:    exp_rd = {28'h0, m_ctrl};
        2'd2:    exp_rd = {29'h0, m_err, m_done, 1'(m_active)};
        default: exp_rd = {16'h0, m_rdata};
      endcase
      chk("readdata", readdata, exp_rd);
      chk("cs_n", 32'(otg_hpi_cs_n), 32'(!cs_low));
      chk("r_n", 32'(otg_hpi_r_n), 32'(!(str_low && m_dir)));
      chk("w_n", 32'(otg_hpi_w_n), 32'(!(str_low && !m_dir)));
      chk("hpi_addr", 32'(otg_hpi_addr), m_active ? 32'(m_port) : 32'h0);
      chk("data_oe", 32'(otg_data_oe), 32'(oe));
      chk("data_out", 32'(otg_data_out), oe ? 32'(m_wdata) : 32'h0);
      chk("strobe_excl", 32'(!otg_hpi_r_n && !otg_hpi_w_n), 32'h0);
      chk("strobe_without_cs", 32'((!otg_hpi_r_n || !otg_hpi_w_n) && otg_hpi_cs_n), 32'h0);
`ifdef OTG_HPI_IRQ_EN
      chk("irq", 32'(irq), 32'(m_done && m_ctrl[3]));
`endif
    end
  end

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
  endtask

  // Watches one transaction clock by clock; k=1 is the clock that accepted CTRL.
  task automatic measure(output int str_cnt, output int oe_cnt, output int done_k,
                         output int first_cs, output int first_str,
                         output logic [1:0] addr_s, output logic [15:0] dout_s);
    str_cnt = 0; oe_cnt = 0; done_k = -1; first_cs = -1; first_str = -1; addr_s = 0; dout_s = 0;
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      @(negedge clk);
      if (!otg_hpi_cs_n && first_cs < 0) first_cs = k;
      if (!otg_hpi_r_n || !otg_hpi_w_n) begin
        if (first_str < 0) first_str = k;
        str_cnt++;
        addr_s = otg_hpi_addr;
        dout_s = otg_data_out;
      end
      if (otg_data_oe) oe_cnt++;
      if (readdata[1]) done_k = k;
    end
    if (done_k < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done never set within 20 clocks");
    end
  endtask

  task automatic read_reg(input logic [1:0] a, input string name, input logic [31:0] exp);
    @(posedge clk); #2; address = a;
    @(negedge clk); chk(name, readdata, exp);
  endtask

  int sc, oc, dk, fc, fs;
  logic [1:0]  as;
  logic [15:0] ds;

  initial begin
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
    writedata = '0; otg_data_in = '0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_status", readdata, 32'h0);
    chk("reset_cs_n", 32'(otg_hpi_cs_n), 32'h1);

    // Write to port 2.
    avl_write(2'd0, 32'h0000_1234);
    avl_write(2'd1, 32'h2);
    measure(sc, oc, dk, fc, fs, as, ds);
    chk("wr_strobe_clocks", 32'(sc), 32'd4);
    chk("wr_cs_lead", 32'(fs - fc), 32'd1);
    chk("wr_done_clock", 32'(dk), 32'd9);
    chk("wr_hpi_addr", 32'(as), 32'h2);
    chk("wr_data_out", 32'(ds), 32'h1234);
    chk("wr_status", readdata, 32'h2);

    // Sticky clear.
    avl_write(2'd2, 32'h6);
    @(negedge clk); chk("clear_status", readdata, 32'h0);

    // Read from port 0.
    otg_data_in = 16'hBEEF;
    avl_write(2'd1, 32'h4);
    measure(sc, oc, dk, fc, fs, as, ds);
    chk("rd_strobe_clocks", 32'(sc), 32'd4);
    chk("rd_oe_clocks", 32'(oc), 32'd0);
    chk("rd_done_clock", 32'(dk), 32'd9);
    read_reg(2'd3, "rd_rdata", 32'h0000_BEEF);
    read_reg(2'd2, "rd_status", 32'h2);

    // CTRL write while busy.
    avl_write(2'd1, 32'h2);
    @(posedge clk); #2;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h7;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
    @(negedge clk);
    chk("busy_collide_status", readdata, 32'h5);
    chk("busy_collide_port", 32'(otg_hpi_addr), 32'h2);
    dk = -1;
    for (int k = 3; k <= 20 && dk < 0; k++) begin
      if (readdata[1]) dk = k;
      else @(negedge clk);
    end
    chk("busy_collide_done_clock", 32'(dk), 32'd9);
    chk("busy_collide_final", readdata, 32'h6);
    read_reg(2'd1, "busy_collide_ctrl", 32'h2);

    // Same-clock done set and clear.
    avl_write(2'd2, 32'h6);
    avl_write(2'd1, 32'h4);
    repeat (7) @(posedge clk);
    #2; chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h2;
    @(posedge clk); #2; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk); chk("set_beats_clear", readdata, 32'h2);

    // Reset during STROBE.
    avl_write(2'd0, 32'h5A5A);
    avl_write(2'd1, 32'h2);
    @(posedge clk); #2;
    chk("pre_reset_in_strobe", 32'(otg_hpi_w_n), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("async_cs_n", 32'(otg_hpi_cs_n), 32'h1);
    chk("async_w_n", 32'(otg_hpi_w_n), 32'h1);
    chk("async_oe", 32'(otg_data_oe), 32'h0);
    chk("async_addr", 32'(otg_hpi_addr), 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk); chk("post_reset_status", readdata, 32'h0);

`ifdef OTG_HPI_IRQ_EN
    avl_write(2'd1, 32'hC);
    measure(sc, oc, dk, fc, fs, as, ds);
    chk("irq_with_done", 32'(irq), 32'h1);
    avl_write(2'd2, 32'h2);
    @(negedge clk); chk("irq_cleared", 32'(irq), 32'h0);
`endif

    // Random bus traffic, model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      otg_data_in = 16'($urandom);
      address     = 2'($urandom_range(0, 3));
      writedata   = $urandom;
      chipselect  = ($urandom_range(0, 99) < 60);
      write_n     = !($urandom_range(0, 99) < 20);
    end
    @(posedge clk); #2; chipselect = 1'b0; write_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/otg_hpi_sequencer.md
Name: otg_hpi_sequencer

Overview:
- Hardware sequencer for the CY7C67200 (USB OTG) Host Port Interface.
- Replaces software bit-banging of the separate HPI address, data, cs, rd and wr PIOs with one Avalon-MM slave.
- The CPU loads a data word and a command. The block then runs one timed HPI read or write cycle on the OTG pins and reports completion.
- Sits between the Nios II system interconnect and the top-level OTG pin drivers (tristate buffer lives in the top level).

Parameters:
- SETUP_CYC, 1, clocks with cs_n low and address/data valid before the strobe (1..15)
- STROBE_CYC, 4, clocks r_n or w_n is held low (1..15)
- HOLD_CYC, 1, clocks cs_n stays low after the strobe rises (0..15)
- RECOVERY_CYC, 2, clocks cs_n stays high before busy clears (0..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational mux, zero-extended
- otg_hpi_addr  out  2  HPI port select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- otg_hpi_cs_n  out  1  HPI chip select, active low
- otg_hpi_r_n  out  1  HPI read strobe, active low
- otg_hpi_w_n  out  1  HPI write strobe, active low
- otg_data_out  out  16  data driven toward the HPI
- otg_data_oe  out  1  tristate enable for otg_data_out
- otg_data_in  in  16  data from the HPI pins

Behaviour:
- Registers (register write = chipselect && !write_n):
  - 0 WDATA: rw, [15:0]
  - 1 CTRL: rw. [1:0] port, [2] dir (1 = read). A write to CTRL starts a transaction.
  - 2 STATUS: [0] busy (ro), [1] done (sticky), [2] err (sticky). Writing 1 to a bit clears it.
  - 3 RDATA: ro, [15:0]
- Reset values (async): all registers 0, state IDLE. cs_n/r_n/w_n = 1, otg_hpi_addr = 0, otg_data_out = 0, otg_data_oe = 0.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One 4-bit down-counter is loaded with (N-1) on each state entry.
- IDLE:
  - A CTRL write latches port/dir and goes to SETUP next clock. busy=1, done cleared.
  - otg_hpi_addr is driven from the latched port for the whole transaction.
  - For a write, otg_data_out = WDATA and oe=1 from SETUP through HOLD.
- SETUP: cs_n=0 for SETUP_CYC clocks, then STROBE.
- STROBE:
  - r_n=0 (read) or w_n=0 (write) for STROBE_CYC clocks.
  - Read: otg_data_in is captured into RDATA on the last STROBE clock.
  - Then HOLD, or RECOVER directly if HOLD_CYC=0.
- HOLD: strobes high, cs_n=0, for HOLD_CYC clocks.
- RECOVER: cs_n=1, oe=0, for RECOVERY_CYC clocks. On exit: IDLE, busy=0, done=1.
- Zero-cycle states (HOLD_CYC or RECOVERY_CYC = 0) are skipped, not run for one cycle.
- Write n (write_n low) and read (r_n low) are never low together. Strobes are never low while cs_n is high.
- CTRL write while busy: ignored, err set, the running transaction is unaffected. WDATA write while busy: ignored, err set.
- Same-clock STATUS clear and done set: set wins.
- Total transaction latency (CTRL write to done) = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVERY_CYC + 1 clocks. Default is 9.
- reset_n asserted mid-transaction: all pins return to reset values immediately, with no completion.

Optional Feature:
- Macro: OTG_HPI_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - CTRL[3] becomes irq_en (rw, reset 0).
  - irq = done & irq_en, a level that clears when done is cleared.
- Undefined:
  - No irq port.
  - CTRL[3] reads 0 and writes to it are ignored.

Test Plan:
- Write: WDATA=0x1234, CTRL=0x2 (port 2, write) -> cs_n low 1 clk before w_n; w_n low exactly 4 clks; otg_hpi_addr=2; otg_data_out=0x1234 with oe=1; done=1 and busy=0 at clock 9.
- Read: CTRL=0x4 (port 0, read), otg_data_in=0xBEEF during strobe -> r_n low 4 clks, oe never 1, RDATA reads 0x0000BEEF, STATUS=0x2.
- Busy collision: CTRL=0x2 then CTRL=0x7 at clock 3 -> second command ignored, port stays 2, STATUS reads 0x5 at clock 4, done follows at clock 9.
- Sticky clear: after done, write STATUS=0x6 -> STATUS reads 0x0; a same-clock done set and clear leaves done=1.
- Reset mid-op: drop reset_n during STROBE -> cs_n/w_n high, oe=0, addr 0 asynchronously; STATUS=0 after release.
- OTG_HPI_IRQ_EN: CTRL=0xC (read, irq_en) -> irq rises with done; write STATUS=0x2 -> irq falls next clock.
